// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank command sequencer: command opcodes, controller
// states and the op/mask to per-bit J/K mapping.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // A masked-off bit always gets J=K=0 so it holds regardless of the op.
  function automatic jk_t jk_map(input op_e op, input logic m);
    jk_t r;
    r = '0;
    if (m) begin
      case (op)
        OP_CLEAR:  r = '{j: 1'b0, k: 1'b1};
        OP_SET:    r = '{j: 1'b1, k: 1'b0};
        OP_TOGGLE: r = '{j: 1'b1, k: 1'b1};
        default:   r = '{j: 1'b0, k: 1'b0};
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// WIDTH independent JK flip-flops with synchronous active-high reset to 0.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer in front of a JK bank: accepts one op/mask/count command,
// drives J/K for count+1 cycles (or until abort), then pulses done.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready never depends on cmd_valid.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] j_vec, k_vec;
  jk_t              jk_bit;

  assign cmd_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    j_vec     = '0;
    k_vec     = '0;
    jk_bit    = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = op_e'(cmd_op);
          mask_d  = cmd_mask;
          rem_d   = cmd_count;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Abort wins over the pending update: the bank is left untouched.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            jk_bit   = jk_map(op_q, mask_q[i]);
            j_vec[i] = jk_bit.j;
            k_vec[i] = jk_bit.k;
          end
          if (rem_q == '0) state_d = DONE;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      DONE: begin
        aborted_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_HOLD;
      mask_q    <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .reset (reset),
    .j     (j_vec),
    .k     (k_vec),
    .q     (q)
  );

  assign busy      = (state_q == EXEC) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign aborted   = (state_q == DONE) && aborted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl; each task covers one scenario
// with hand-computed expected values.
module tb_jk_bank_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam logic [1:0] C_HOLD   = 2'b00;
  localparam logic [1:0] C_CLEAR  = 2'b01;
  localparam logic [1:0] C_SET    = 2'b10;
  localparam logic [1:0] C_TOGGLE = 2'b11;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [1:0]       dbg_state;

  int n_checks;
  int n_fail;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_op    = C_HOLD;
    cmd_mask  = '0;
    cmd_count = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Present a command in IDLE and take it through the accept edge E0.
  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                          input logic [CNT_W-1:0] cnt);
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Run a command to completion without checks beyond a timeout.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                         input logic [CNT_W-1:0] cnt);
    int guard;
    send_cmd(op, mask, cnt);
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL run_cmd_timeout busy=%b required 0", busy);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL reset_ready_gated got %b required 0", cmd_ready); n_fail++;
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({q, busy, done, aborted, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL reset_values q=%h busy=%b done=%b aborted=%b ready=%b required 00 0 0 0 1",
               q, busy, done, aborted, cmd_ready);
      n_fail++;
    end
  endtask

  task automatic test_toggle();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 8'h0F; exp_q[1] = 8'h00; exp_q[2] = 8'h0F;
    send_cmd(C_TOGGLE, 8'h0F, 4'd2);
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      $display("FAIL toggle_accept busy=%b ready=%b required 1 0", busy, cmd_ready); n_fail++;
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (q !== exp_q[e]) begin
        $display("FAIL toggle_q_E%0d got %h required %h", e + 1, q, exp_q[e]); n_fail++;
      end
      n_checks++;
      if (done !== (e == 2)) begin
        $display("FAIL toggle_done_E%0d got %b required %b", e + 1, done, (e == 2)); n_fail++;
      end
    end
    n_checks++;
    if (aborted !== 1'b0) begin
      $display("FAIL toggle_aborted got %b required 0", aborted); n_fail++;
    end
    tick();
    n_checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL toggle_return_idle done=%b busy=%b ready=%b required 0 0 1",
               done, busy, cmd_ready);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int accept_cyc [$];
    do_reset();
    cmd_op = C_SET; cmd_mask = 8'hA5; cmd_count = 4'd0; cmd_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (cmd_valid && cmd_ready) accept_cyc.push_back(c);
      tick();
      if (c == 0) begin
        cmd_op = C_CLEAR; cmd_mask = 8'h05;
      end
      if (c == 1) begin
        n_checks++;
        if (q !== 8'hA5 || done !== 1'b1) begin
          $display("FAIL b2b_first q=%h done=%b required a5 1", q, done); n_fail++;
        end
      end
      if (c == 3) cmd_valid = 1'b0;
    end
    n_checks++;
    if (q !== 8'hA0) begin
      $display("FAIL b2b_second_q got %h required a0", q); n_fail++;
    end
    n_checks++;
    if (accept_cyc.size() != 2) begin
      $display("FAIL b2b_accept_count got %0d required 2", accept_cyc.size()); n_fail++;
    end else begin
      n_checks++;
      if (accept_cyc[1] - accept_cyc[0] != 3) begin
        $display("FAIL b2b_period got %0d required 3", accept_cyc[1] - accept_cyc[0]); n_fail++;
      end
    end
  endtask

  task automatic test_hold_max_count();
    int busy_cnt;
    int done_tick;
    int guard;
    do_reset();
    run_cmd(C_SET, 8'h3C, 4'd0);
    send_cmd(C_HOLD, 8'hFF, 4'd15);
    busy_cnt  = busy ? 1 : 0;
    done_tick = -1;
    guard     = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) busy_cnt++;
      if (done && done_tick < 0) done_tick = guard;
      n_checks++;
      if (q !== 8'h3C) begin
        $display("FAIL hold_q_tick%0d got %h required 3c", guard, q); n_fail++;
      end
    end
    n_checks++;
    if (busy_cnt != 17) begin
      $display("FAIL hold_busy_cycles got %0d required 17", busy_cnt); n_fail++;
    end
    n_checks++;
    if (done_tick != 16) begin
      $display("FAIL hold_done_edge got %0d required 16", done_tick); n_fail++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    send_cmd(C_TOGGLE, 8'h01, 4'd7);
    tick();
    n_checks++;
    if (q !== 8'h01) begin
      $display("FAIL abort_q_E1 got %h required 01", q); n_fail++;
    end
    tick();
    n_checks++;
    if (q !== 8'h00) begin
      $display("FAIL abort_q_E2 got %h required 00", q); n_fail++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({q, done, aborted} !== {8'h00, 1'b1, 1'b1}) begin
      $display("FAIL abort_E3 q=%h done=%b aborted=%b required 00 1 1", q, done, aborted);
      n_fail++;
    end
    tick();
    n_checks++;
    if ({done, aborted, cmd_ready} !== 3'b001) begin
      $display("FAIL abort_clear done=%b aborted=%b ready=%b required 0 0 1",
               done, aborted, cmd_ready);
      n_fail++;
    end
    // abort in IDLE has no effect on a following normal command
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_cmd(C_SET, 8'h80, 4'd0);
    n_checks++;
    if (q !== 8'h80) begin
      $display("FAIL abort_idle_ignored q=%h required 80", q); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    do_reset();
    send_cmd(C_SET, 8'hFF, 4'd5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({q, busy, done, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL midreset_E3 q=%h busy=%b done=%b ready=%b required 00 0 0 0",
               q, busy, done, cmd_ready);
      n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL midreset_ready got %b required 1", cmd_ready); n_fail++;
    end
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || q !== 8'h00) begin
      $display("FAIL midreset_no_done done_pulses=%0d q=%h required 0 00", done_seen, q);
      n_fail++;
    end
  endtask

  task automatic test_ignore_inputs();
    int accepts;
    do_reset();
    send_cmd(C_SET, 8'h11, 4'd3);
    accepts = 0;
    for (int e = 1; e <= 4; e++) begin
      cmd_op    = C_TOGGLE;
      cmd_mask  = 8'hFF;
      cmd_count = 4'd0;
      cmd_valid = (e <= 2);
      if (cmd_valid && cmd_ready) accepts++;
      tick();
      n_checks++;
      if (q !== 8'h11) begin
        $display("FAIL ignore_q_E%0d got %h required 11", e, q); n_fail++;
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || accepts != 0) begin
      $display("FAIL ignore_done done=%b accepts=%0d required 1 0", done, accepts); n_fail++;
    end
    tick();
    tick();
    n_checks++;
    if ({busy, q} !== {1'b0, 8'h11}) begin
      $display("FAIL ignore_after busy=%b q=%h required 0 11", busy, q); n_fail++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = C_HOLD;
    cmd_mask  = '0;
    cmd_count = '0;
    abort     = 1'b0;
    test_reset();
    test_toggle();
    test_back_to_back();
    test_hold_max_count();
    test_abort();
    test_reset_mid();
    test_ignore_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command sequencer for an N-bit bank of JK flip-flops. It accepts SET / CLEAR / TOGGLE / HOLD commands through a valid/ready handshake. Each command carries a bit mask and a repeat count. The block drives per-bit J/K for the required number of cycles, then reports completion. It is the control layer placed in front of the JK storage primitives, for use as a programmable flag or toggle register.

## Interface
Parameters:
- WIDTH, 8, number of JK bits in the bank
- CNT_W, 4, width of the repeat-count field

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE
- cmd_mask  in  WIDTH  bits affected; unmasked bits get J=K=0
- cmd_count  in  CNT_W  command executes cmd_count+1 cycles
- abort  in  1  terminate the running command
- q  out  WIDTH  bank contents
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done; high only when the command ended by abort

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1 (forced 0 while reset is high).
  - A handshake (cmd_valid & cmd_ready) at an edge latches op, mask and rem = cmd_count, then moves to EXEC.
- EXEC:
  - J/K per bit i: mask[i]=0 gives 00. HOLD gives 00, CLEAR gives 01, SET gives 10, TOGGLE gives 11.
  - At each edge: q updates with JK semantics (00 hold, 01 clear, 10 set, 11 invert).
  - If rem==0, go to DONE; otherwise rem decrements.
- abort in EXEC:
  - At that edge J/K are forced to 00, so q is not updated.
  - Next state is DONE with the aborted flag set.
  - abort is ignored in IDLE and DONE.
- DONE:
  - done = 1 for exactly one cycle; aborted = latched flag.
  - Next edge returns to IDLE and clears the flag.
- Latched op and mask are stable for the whole command; input changes after acceptance have no effect.
- Count width: rem is CNT_W bits. Maximum execution is 2^CNT_W cycles (count=15 gives 16 cycles); no wrap.
- Reset mid-operation:
  - Next edge: q = 0, state IDLE, rem = 0, aborted flag = 0.
  - The in-flight command is discarded with no done pulse.

## Timing
- Reset values: q=0, busy=0, done=0, aborted=0, cmd_ready=1 once reset is deasserted.
- Accept edge E0; q updates at edges E1..E(count+1); done is high in the cycle after E(count+1).
- cmd_ready is high again one cycle after done.
- Command period: count+3 cycles. Back-to-back commands with cmd_valid held high are accepted every count+3 cycles.
- abort sampled at edge Ek (k ≥ 1): q keeps its value from Ek-1, and done/aborted are high in the cycle after Ek.
- cmd_ready, busy, done and aborted are registered-state decodes with no combinational path from cmd_valid. The only exception is the reset gating on cmd_ready.

## Structure
- Shared package jk_ctrl_pkg:
  - op enum (OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11)
  - state enum (IDLE, EXEC, DONE)
  - function mapping op+mask to J/K vectors
- Sub-module jk_bank:
  - WIDTH JK flops with per-bit j/k inputs and synchronous active-high reset to 0.
  - Instantiated once; the controller owns only the FSM, the counter and the latched command.

## Test plan
- Reset, then TOGGLE mask 8'h0F count 2 → q after E1/E2/E3 = 0x0F/0x00/0x0F; done in cycle E3+1; aborted=0.
- SET mask 8'hA5 count 0 from q=0, then CLEAR mask 8'h05 count 0 with valid held → q=0xA5, then 0xA0; second accept exactly 3 cycles after the first.
- HOLD mask 8'hFF count 15 with q=0x3C → q stays 0x3C for 16 EXEC cycles; done after cycle 16; busy high for 17 cycles.
- TOGGLE mask 8'h01 count 7, abort at E3 → q toggles at E1 and E2 only (ends 0x00 from 0x00); done=aborted=1 in cycle E3+1.
- SET mask 8'hFF count 5, reset at E2 → q=0 after E3, no done pulse, cmd_ready=1 after reset deasserts.
- Change cmd_op/cmd_mask and pulse cmd_valid during EXEC → no second accept, q follows the latched command only.
